scrambler_64b66b_lane: RTL
==========================

SCRAMBLER_64B66B_LANE -- requirements
Module: scrambler_64b66b_lane

Interface
REQ-001 SHALL have parameter LEN, default 32: data word width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter RX, default 0: 0 = scramble (TX), 1 = descramble (RX).
REQ-003 SHALL have parameter SEED, default 58'h3FF_FFFF_FFFF_FFFF: LFSR reset value.
REQ-004 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port nreset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port valid_i  in  1  input word valid.
REQ-007 SHALL have port ready_o  out  1  input word accepted when valid_i & ready_o.
REQ-008 SHALL have port data_i  in  LEN  input word; bit 0 is first on the wire.
REQ-009 SHALL have port head_i  in  2  sync header, sampled only on the first word of a block.
REQ-010 SHALL have port valid_o  out  1  output word valid.
REQ-011 SHALL have port ready_i  in  1  downstream ready.
REQ-012 SHALL have port data_o  out  LEN  scrambled (TX) or descrambled (RX) word.
REQ-013 SHALL have port head_o  out  2  sync header, unscrambled, held for the whole block.
REQ-014 SHALL have port sob_o  out  1  output word is the first word of a 66-bit block.

Function
REQ-015 SHALL implement polynomial x^58 + x^39 + 1 over a 58-bit state S; S[0] is the most recent scrambled bit.
REQ-016 SHALL compute, per bit n from 0 to LEN-1 in order, out = in ^ S[38] ^ S[57], then shift S left by one, inserting the scrambled bit: out in TX, in in RX.
REQ-017 SHALL advance S and the block word counter only on an accepted input transfer (valid_i & ready_o).
REQ-018 SHALL register outputs: a word accepted in cycle N appears on data_o/valid_o in cycle N+1.
REQ-019 SHALL drive ready_o = ~valid_o | ready_i, giving full throughput with no bubble under continuous ready_i.
REQ-020 SHALL hold data_o, head_o, sob_o and valid_o stable while valid_o & ~ready_i.
REQ-021 SHALL clear valid_o after a transfer (valid_o & ready_i) with no new input accepted.
REQ-022 SHALL keep a word counter 0..(64/LEN)-1 that wraps to 0 after the last word; sob_o is set for the word accepted at count 0.
REQ-023 SHALL capture head_i at count 0 and output it on head_o for every word of that block.
REQ-024 SHALL pass the sync header unscrambled; it SHALL never enter S.
REQ-025 For LEN=64, SHALL hold the counter at 0 and set sob_o on every word.

Reset
REQ-026 SHALL, while nreset=0 at a clock edge, set S=SEED, counter=0, valid_o=0, data_o=0, head_o=2'b00 and sob_o=0.
REQ-027 SHALL drop any word held at the output when reset is asserted mid-block; the first word accepted after reset is treated as start of block.

Configuration
REQ-028 With SCRAMBLER_BYPASS_EN defined, SHALL add port bypass_i (in, 1): when 1 on an accepted word, data_o = data_i, S still advances as in REQ-016, and handshake and latency are unchanged.
REQ-029 Without SCRAMBLER_BYPASS_EN, SHALL have no bypass_i port and SHALL always scramble or descramble.

Structure
REQ-030 SHALL take from the shared 64b66b package: the LFSR width (58), tap positions (38, 57), default seed, block width (64), and the header constants 2'b01 (data) and 2'b10 (control).
REQ-031 SHALL place the per-word combinational LEN-bit LFSR unroll in sub-module scrambler_64b66b_lfsr_step; the top holds registers, counter and handshake.

Verification
REQ-032 TX, LEN=32, seed all-ones, data_i 32'h0 then 32'h0, ready_i=1 -> data_o 32'h0000_0000 then 32'h03FF_FF80; sob_o 1 then 0.
REQ-033 Loopback TX->RX, LEN=32, 1000 random words -> RX data_o equals TX data_i bit-exact, including the 58-bit resync when RX starts with a different seed, after the first 2 words.
REQ-034 ready_i=0 for 3 cycles with valid_i=1 -> ready_o=0, data_o stable, S unchanged; on release each word is seen exactly once.
REQ-035 LEN=16, head_i=2'b10 on word 0 and 2'b01 on words 1-3 -> head_o=2'b10 on all 4 output words, sob_o pattern 1,0,0,0, then repeats.
REQ-036 nreset asserted after word 1 of a LEN=16 block -> valid_o=0 next cycle; next accepted word has sob_o=1 and the scrambled output matches the all-ones seed.
REQ-037 SCRAMBLER_BYPASS_EN, bypass_i=1 for word 0 and 0 for word 1, both 32'h0 -> data_o 32'h0 then 32'h03FF_FF80.

Source files
------------

// File: rtl/scrambler_64b66b_pkg.sv
// Shared 64b/66b constants: LFSR geometry, default seed,
// block width and the two legal sync header values.
package scrambler_64b66b_pkg;

  localparam int LFSR_W  = 58;
  localparam int TAP_A   = 38;
  localparam int TAP_B   = 57;
  localparam int BLOCK_W = 64;

  localparam logic [LFSR_W-1:0] SEED_DEFAULT =
    58'h3FF_FFFF_FFFF_FFFF;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  typedef logic [LFSR_W-1:0] lfsr_t;

endpackage

// File: rtl/scrambler_64b66b_lfsr_step.sv
// One word of x^58+x^39+1 (de)scrambling, unrolled over LEN bits.
// Ports: state/din in; dout (processed word) and next state out.
module scrambler_64b66b_lfsr_step
  import scrambler_64b66b_pkg::*;
#(
  parameter int LEN = 32,
  parameter int RX  = 0
) (
  input  lfsr_t          state,
  input  logic [LEN-1:0] din,
  output logic [LEN-1:0] dout,
  output lfsr_t          next
);

  lfsr_t s;

  // Bit 0 is first on the wire. The shifted-in bit is always the
  // scrambled one: our output on TX, the received bit on RX.
  always_comb begin
    s    = state;
    dout = '0;
    for (int n = 0; n < LEN; n++) begin
      dout[n] = din[n] ^ s[TAP_A] ^ s[TAP_B];
      s = {s[LFSR_W-2:0], (RX != 0) ? din[n] : dout[n]};
    end
    next = s;
  end

endmodule

// File: rtl/scrambler_64b66b_lane.sv
// 64b/66b lane (de)scrambler with registered valid/ready output.
// Ports: clk, nreset (sync, active-low); valid_i/ready_o/data_i/head_i
// upstream; valid_o/ready_i/data_o/head_o/sob_o downstream.
// Optional: SCRAMBLER_BYPASS_EN adds bypass_i (word passes unscrambled).
module scrambler_64b66b_lane
  import scrambler_64b66b_pkg::*;
#(
  parameter int    LEN  = 32,
  parameter int    RX   = 0,
  parameter lfsr_t SEED = SEED_DEFAULT
) (
  input  logic           clk,
  input  logic           nreset,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic           bypass_i,
`endif
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [LEN-1:0] data_i,
  input  logic [1:0]     head_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [LEN-1:0] data_o,
  output logic [1:0]     head_o,
  output logic           sob_o
);

  localparam int WPB = BLOCK_W / LEN;
  localparam int CW  = (WPB > 1) ? $clog2(WPB) : 1;

  lfsr_t          s;
  lfsr_t          s_nxt;
  logic [LEN-1:0] step_out;
  logic [LEN-1:0] word_out;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           first;
  logic           last;

  scrambler_64b66b_lfsr_step #(
    .LEN (LEN),
    .RX  (RX)
  ) u_step (
    .state (s),
    .din   (data_i),
    .dout  (step_out),
    .next  (s_nxt)
  );

`ifdef SCRAMBLER_BYPASS_EN
  assign word_out = bypass_i ? data_i : step_out;
`else
  assign word_out = step_out;
`endif

  assign ready_o = ~valid_o | ready_i;
  assign accept  = valid_i & ready_o;
  assign first   = (cnt == '0);
  // With LEN=64 WPB-1 is 0, so every word is both first and last.
  assign last    = (cnt == CW'(WPB - 1));

  // head_o only reloads on a block's first word, so it keeps
  // showing that block's header for the remaining words.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      s       <= SEED;
      cnt     <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      head_o  <= 2'b00;
      sob_o   <= 1'b0;
    end else if (accept) begin
      s       <= s_nxt;
      cnt     <= last ? '0 : cnt + 1'b1;
      valid_o <= 1'b1;
      data_o  <= word_out;
      sob_o   <= first;
      if (first) head_o <= head_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule
